// File: rtl/clk_phase_gen.sv
// rtl/clk_phase_gen.sv - multi-phase programmable clock divider with shadowed, boundary-applied config
// Optional programmable high time: define CLK_PHASE_GEN_DUTY_EN.
module clk_phase_gen #(
  parameter int DIV_WIDTH  = 8,
  parameter int NUM_PHASES = 4,
  parameter int SEL_WIDTH  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
  parameter int RESET_DIV  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic                  cfg_div_we,
  input  logic [SEL_WIDTH-1:0]  cfg_sel,
  input  logic [DIV_WIDTH-1:0]  cfg_off,
  input  logic                  cfg_off_we,
  input  logic                  cfg_commit,
`ifdef CLK_PHASE_GEN_DUTY_EN
  input  logic [DIV_WIDTH-1:0]  cfg_high,
  input  logic                  cfg_high_we,
`endif
  output logic                  cfg_pending,
  output logic [NUM_PHASES-1:0] phase_clk,
  output logic                  sync_pulse,
  output logic                  running
);
  localparam int CW = DIV_WIDTH + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] RESET_P = CW'(RESET_DIV + 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;

  logic [CW-1:0]        cnt, cnt_n;
  logic [CW-1:0]        per;
  logic [CW-1:0]        per_new;
  logic [CW-1:0]        high;
  logic [DIV_WIDTH-1:0] div_sh;
  logic [DIV_WIDTH-1:0] off_sh  [NUM_PHASES];
  logic [DIV_WIDTH-1:0] off_act [NUM_PHASES];
  logic [NUM_PHASES-1:0] phase_n;
  logic run_en, wrap, apply;

  function automatic logic phase_hi(input logic [CW-1:0] c, input logic [CW-1:0] o,
                                    input logic [CW-1:0] p, input logic [CW-1:0] h);
    logic [CW-1:0] d;
    d = (c >= o) ? c - o : c + p - o;
    return d < h;
  endfunction

  function automatic logic [DIV_WIDTH-1:0] clamp_off(input logic [DIV_WIDTH-1:0] o,
                                                     input logic [CW-1:0] p);
    return (CW'(o) > p - ONE) ? DIV_WIDTH'(p - ONE) : o;
  endfunction

  assign per_new = (div_sh == '0) ? CW'(2) : CW'(div_sh) + ONE;
  assign run_en  = (state == RUN) && enable;
  assign wrap    = (cnt == per - ONE);
  // Apply only on a period boundary: entering RUN or the P-1 -> 0 wrap.
  assign apply   = cfg_pending && enable && ((state == IDLE) || wrap);
  assign running = (state == RUN);

`ifdef CLK_PHASE_GEN_DUTY_EN
  logic [DIV_WIDTH-1:0] high_sh;
  logic [CW-1:0]        high_act, high_new;

  always_comb begin
    high_new = CW'(high_sh);
    if (high_new == '0)
      high_new = ONE;
    else if (high_new > per_new - ONE)
      high_new = per_new - ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_sh  <= DIV_WIDTH'(RESET_P >> 1);
      high_act <= RESET_P >> 1;
    end else begin
      if (cfg_high_we) high_sh <= cfg_high;
      if (apply)       high_act <= high_new;
    end
  end

  assign high = high_act;
`else
  assign high = per >> 1;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    case (state)
      IDLE: if (enable) state_n = RUN;
      RUN: begin
        if (!enable)   state_n = IDLE;
        else if (!wrap) cnt_n = cnt + ONE;
      end
    endcase
  end

  always_comb begin
    phase_n = '0;
    for (int k = 0; k < NUM_PHASES; k++)
      phase_n[k] = run_en && phase_hi(cnt, CW'(off_act[k]), per, high);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      per         <= RESET_P;
      div_sh      <= DIV_WIDTH'(RESET_DIV);
      cfg_pending <= 1'b0;
      phase_clk   <= '0;
      sync_pulse  <= 1'b0;
      for (int k = 0; k < NUM_PHASES; k++) begin
        off_sh[k]  <= '0;
        off_act[k] <= '0;
      end
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      phase_clk   <= phase_n;
      sync_pulse  <= run_en && (cnt == '0);
      cfg_pending <= apply ? 1'b0 : (cfg_pending | cfg_commit);
      if (cfg_div_we) div_sh <= cfg_div;
      if (apply)      per    <= per_new;
      for (int k = 0; k < NUM_PHASES; k++) begin
        if (cfg_off_we && cfg_sel == SEL_WIDTH'(k)) off_sh[k] <= cfg_off;
        if (apply) off_act[k] <= clamp_off(off_sh[k], per_new);
      end
    end
  end
endmodule

// File: tb/tb_clk_phase_gen.sv
// tb/tb_clk_phase_gen.sv - scoreboard bench for clk_phase_gen (default build, 4 phases)
module tb_clk_phase_gen;
  logic       clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [7:0] cfg_div = '0, cfg_off = '0;
  logic [1:0] cfg_sel = '0;
  logic       cfg_div_we = 1'b0, cfg_off_we = 1'b0, cfg_commit = 1'b0;
  logic       cfg_pending, sync_pulse, running;
  logic [3:0] phase_clk;

  clk_phase_gen dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_div(cfg_div), .cfg_div_we(cfg_div_we),
    .cfg_sel(cfg_sel), .cfg_off(cfg_off), .cfg_off_we(cfg_off_we),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
    .phase_clk(phase_clk), .sync_pulse(sync_pulse), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic sy; logic [3:0] ph; } exp_t;
  exp_t sbq[$];
  int checks = 0, failures = 0;
  int m_p = 8, m_h = 4;
  int m_off[4] = '{0, 0, 0, 0};
  int sh_off[4] = '{0, 0, 0, 0};
  int sh_div = 7;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_apply();
    m_p = (sh_div == 0) ? 2 : sh_div + 1;
    m_h = m_p / 2;
    for (int k = 0; k < 4; k++) m_off[k] = (sh_off[k] > m_p - 1) ? m_p - 1 : sh_off[k];
  endtask

  task automatic model_reset();
    sh_div = 7;
    for (int k = 0; k < 4; k++) begin sh_off[k] = 0; m_off[k] = 0; end
    m_p = 8;
    m_h = 4;
  endtask

  task automatic push_cycles(input int start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      int c;
      c = (start + i) % m_p;
      e.sy = (c == 0);
      for (int k = 0; k < 4; k++) e.ph[k] = (((c - m_off[k] + m_p) % m_p) < m_h);
      sbq.push_back(e);
    end
  endtask

  task automatic drain(input string name, input int n);
    exp_t e;
    for (int i = 0; i < n && sbq.size() > 0; i++) begin
      e = sbq.pop_front();
      tick();
      checks++;
      if (phase_clk !== e.ph || sync_pulse !== e.sy || running !== 1'b1) begin
        failures++;
        $display("FAIL %s: got phase_clk=%b sync=%b running=%b, expected phase_clk=%b sync=%b running=1",
                 name, phase_clk, sync_pulse, running, e.ph, e.sy);
      end
    end
  endtask

  task automatic write_off(input int k, input int v);
    cfg_sel = 2'(k); cfg_off = 8'(v); cfg_off_we = 1'b1;
    tick();
    cfg_off_we = 1'b0;
    sh_off[k] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if (phase_clk !== 4'b0 || sync_pulse !== 1'b0 || running !== 1'b0 || cfg_pending !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: phase=%b sync=%b run=%b pend=%b, expected all 0",
               phase_clk, sync_pulse, running, cfg_pending);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_default();
    enable = 1'b1;
    tick();
    checks++;
    if (running !== 1'b1 || phase_clk !== 4'b0 || sync_pulse !== 1'b0) begin
      failures++;
      $display("FAIL default_start: run=%b phase=%b sync=%b, expected 1/0000/0", running, phase_clk, sync_pulse);
    end
    push_cycles(0, 16);
    drain("default", 16);
    enable = 1'b0;
    tick();
    checks++;
    if (running !== 1'b0 || phase_clk !== 4'b0 || sync_pulse !== 1'b0) begin
      failures++;
      $display("FAIL default_stop: run=%b phase=%b sync=%b, expected 0", running, phase_clk, sync_pulse);
    end
  endtask

  task automatic test_offsets();
    for (int k = 0; k < 4; k++) write_off(k, 2 * k);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    tick();
    checks++;
    if (cfg_pending !== 1'b1) begin
      failures++;
      $display("FAIL idle_hold_pending: got %b, expected 1", cfg_pending);
    end
    enable = 1'b1;
    tick();
    model_apply();
    checks++;
    if (cfg_pending !== 1'b0 || running !== 1'b1) begin
      failures++;
      $display("FAIL offsets_apply: pend=%b run=%b, expected 0/1", cfg_pending, running);
    end
    push_cycles(0, 16);
    drain("offsets", 16);
  endtask

  task automatic test_div_change();
    push_cycles(0, 8);
    drain("div_old_head", 3);
    cfg_div = 8'd3; cfg_div_we = 1'b1; cfg_commit = 1'b1;
    drain("div_old_cmd", 1);
    cfg_div_we = 1'b0; cfg_commit = 1'b0;
    sh_div = 3;
    checks++;
    if (cfg_pending !== 1'b1) begin
      failures++;
      $display("FAIL div_pending_set: got %b, expected 1", cfg_pending);
    end
    drain("div_old_tail", 4);
    checks++;
    if (cfg_pending !== 1'b0) begin
      failures++;
      $display("FAIL div_pending_clear: got %b, expected 0", cfg_pending);
    end
    model_apply();
    push_cycles(0, 12);
    drain("div_new", 12);
  endtask

  task automatic test_clamp();
    enable = 1'b0;
    tick();
    cfg_div = 8'd7; cfg_div_we = 1'b1;
    sh_div = 7;
    write_off(1, 9);
    cfg_div_we = 1'b0;
    write_off(0, 0);
    write_off(2, 0);
    write_off(3, 0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    enable = 1'b1;
    tick();
    model_apply();
    push_cycles(0, 16);
    drain("clamp", 16);
  endtask

  task automatic test_enable_toggle();
    push_cycles(0, 3);
    drain("toggle_head", 3);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (running !== 1'b0 || phase_clk !== 4'b0 || sync_pulse !== 1'b0) begin
        failures++;
        $display("FAIL toggle_idle[%0d]: run=%b phase=%b sync=%b, expected 0", i, running, phase_clk, sync_pulse);
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (running !== 1'b1 || sync_pulse !== 1'b0) begin
      failures++;
      $display("FAIL toggle_restart: run=%b sync=%b, expected 1/0", running, sync_pulse);
    end
    push_cycles(0, 8);
    drain("toggle_restart_period", 8);
  endtask

  task automatic test_back_to_back();
    push_cycles(0, 8);
    drain("wrap_head", 7);
    cfg_div = 8'd3; cfg_div_we = 1'b1;
    cfg_sel = 2'd0; cfg_off = 8'd1; cfg_off_we = 1'b1;
    cfg_commit = 1'b1;
    drain("wrap_edge", 1);
    cfg_div_we = 1'b0; cfg_off_we = 1'b0; cfg_commit = 1'b0;
    sh_div = 3;
    sh_off[0] = 1;
    checks++;
    if (cfg_pending !== 1'b1) begin
      failures++;
      $display("FAIL wrap_commit_deferred: pend=%b, expected 1", cfg_pending);
    end
    push_cycles(0, 8);
    drain("wrap_old_period", 8);
    checks++;
    if (cfg_pending !== 1'b0) begin
      failures++;
      $display("FAIL wrap_commit_applied: pend=%b, expected 0", cfg_pending);
    end
    model_apply();
    push_cycles(0, 8);
    drain("wrap_new", 8);
  endtask

  task automatic test_reset_pending();
    push_cycles(0, 2);
    drain("rst_head", 2);
    cfg_div = 8'd5; cfg_div_we = 1'b1; cfg_commit = 1'b1;
    tick();
    cfg_div_we = 1'b0; cfg_commit = 1'b0;
    checks++;
    if (cfg_pending !== 1'b1) begin
      failures++;
      $display("FAIL rst_pending_before: pend=%b, expected 1", cfg_pending);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (phase_clk !== 4'b0 || sync_pulse !== 1'b0 || running !== 1'b0 || cfg_pending !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: phase=%b sync=%b run=%b pend=%b, expected all 0",
               phase_clk, sync_pulse, running, cfg_pending);
    end
    tick();
    reset = 1'b0;
    model_reset();
    enable = 1'b1;
    tick();
    push_cycles(0, 16);
    drain("rst_restart", 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_default();
    test_offsets();
    test_div_change();
    test_clamp();
    test_enable_toggle();
    test_back_to_back();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
